fft_frame_sink: RTL and testbench

//  Receives the Avalon-ST output frames of the FFT core (sop/eop/valid, real/imag).

---
 rtl/fft_frame_sink.sv | 186 ++++++++++++++++++
 tb/tb_fft_frame_sink.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sink.sv
// Frame sink for FFT Avalon-ST output: validates framing and length, parks good frames
// in a two-bank ping-pong RAM and replays each bank as a ready/valid stream.
module fft_frame_sink #(
  parameter int DW      = 25,
  parameter int FFT_LEN = 256,
  parameter int AW      = 8
) (
  input  logic          clk_100m,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic          fft_sop,
  input  logic          fft_eop,
  input  logic [DW-1:0] fft_real,
  input  logic [DW-1:0] fft_imag,
  output logic          fft_ready,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_real,
  output logic [DW-1:0] rd_imag,
  output logic          rd_last,
  output logic          err_sop,
  output logic          err_len,
  output logic [15:0]   frame_cnt
);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);

  typedef enum logic       {W_IDLE, W_FILL}             w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM}  r_state_t;

  w_state_t        r_wstate;
  logic [AW-1:0]   r_widx;
  logic            r_wr_bank;
  logic [1:0]      r_full;
  logic            r_fft_ready;
  logic            r_err_sop;
  logic            r_err_len;
  logic [15:0]     r_frame_cnt;

  r_state_t        r_rstate;
  logic [AW-1:0]   r_ridx;
  logic            r_rd_bank;
  logic            r_rd_valid;
  logic            r_rd_last;
  logic [2*DW-1:0] r_rdata;

  logic [2*DW-1:0] r_mem [2*FFT_LEN];

  logic            w_acc;
  logic            w_we;
  logic [AW-1:0]   w_wr_idx;
  logic [AW:0]     w_wr_addr;
  logic            w_commit;
  logic            w_release;
  logic [1:0]      w_full_nxt;
  logic            w_wr_bank_nxt;
  logic [AW-1:0]   w_ridx_inc;
  logic [AW-1:0]   w_rd_idx;
  logic            w_rd_en;
  logic [AW:0]     w_rd_addr;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    w_acc         = fft_valid & r_fft_ready;
    w_we          = w_acc & (fft_sop | (r_wstate == W_FILL));
    w_wr_idx      = fft_sop ? '0 : r_widx;
    w_wr_addr     = {r_wr_bank, w_wr_idx};
    w_commit      = w_acc & (r_wstate == W_FILL) & ~fft_sop & fft_eop & (r_widx == LAST_IDX);
    w_release     = r_rd_valid & rd_ready & r_rd_last;
    w_full_nxt    = r_full;
    if (w_commit)  w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
    w_wr_bank_nxt = r_wr_bank ^ w_commit;
    w_ridx_inc    = r_ridx + 1'b1;
    w_rd_idx      = (r_rstate == R_IDLE) ? '0 : w_ridx_inc;
    w_rd_en       = ((r_rstate == R_IDLE) & r_full[r_rd_bank]) |
                    (r_rd_valid & rd_ready & ~r_rd_last);
    w_rd_addr     = {r_rd_bank, w_rd_idx};
  end

  always_ff @(posedge clk_100m) begin
    // NOTE: the sample RAM is not reset; the bank-full flags alone decide what is valid.
    if (w_we) r_mem[w_wr_addr] <= {fft_real, fft_imag};
  end

  // Write side: a sop always (re)starts a frame at index 0; only an exact-length frame commits.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_wstate    <= W_IDLE;
      r_widx      <= '0;
      r_wr_bank   <= 1'b0;
      r_full      <= '0;
      r_fft_ready <= 1'b1;
      r_err_sop   <= 1'b0;
      r_err_len   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_err_sop   <= 1'b0;
      r_err_len   <= 1'b0;
      r_full      <= w_full_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_fft_ready <= ~w_full_nxt[w_wr_bank_nxt];
      if (w_commit) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_acc) begin
        case (r_wstate)
          W_IDLE: begin
            if (fft_sop) begin
              r_widx <= AW'(1);
              if (fft_eop) r_err_len <= 1'b1;
              else         r_wstate  <= W_FILL;
            end
          end
          W_FILL: begin
            if (fft_sop) begin
              r_err_sop <= 1'b1;
              r_widx    <= AW'(1);
              if (fft_eop) begin
                r_err_len <= 1'b1;
                r_wstate  <= W_IDLE;
              end
            end else if (fft_eop || (r_widx == LAST_IDX)) begin
              r_wstate <= W_IDLE;
              if (!w_commit) r_err_len <= 1'b1;
            end else begin
              r_widx <= w_ridx_inc_w();
            end
          end
        endcase
      end
    end
  end

  function automatic logic [AW-1:0] w_ridx_inc_w();
    return r_widx + 1'b1;
  endfunction

  // Read side: the RAM output register doubles as the output stage; it only loads
  // when the presented beat is taken, so data holds while rd_ready is low.
  // R_FETCH presents beat 0 from the read issued in R_IDLE.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_rstate   <= R_IDLE;
      r_ridx     <= '0;
      r_rd_bank  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_rd_en) r_rdata <= r_mem[w_rd_addr];
      case (r_rstate)
        R_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_rstate   <= R_FETCH;
            r_ridx     <= '0;
            r_rd_valid <= 1'b1;
            r_rd_last  <= 1'b0;
          end
        end
        R_FETCH, R_STREAM: begin
          if (rd_ready) begin
            if (r_rd_last) begin
              r_rstate   <= R_IDLE;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_rd_bank  <= ~r_rd_bank;
            end else begin
              r_rstate  <= R_STREAM;
              r_ridx    <= w_ridx_inc;
              r_rd_last <= (w_ridx_inc == LAST_IDX);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign fft_ready = r_fft_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_real   = r_rdata[2*DW-1:DW];
  assign rd_imag   = r_rdata[DW-1:0];
  assign rd_last   = r_rd_last;
  assign err_sop   = r_err_sop;
  assign err_len   = r_err_len;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Self-checking bench for fft_frame_sink: directed scenarios plus randomized frames,
// checked against a frame-level reference model (queues of committed samples).
module tb_fft_frame_sink;
  localparam int DW      = 25;
  localparam int FFT_LEN = 256;
  localparam int AW      = 8;
  localparam int TIMEOUT = 5000;

  typedef logic [2*DW-1:0] beat_t;

  logic          clk_100m = 1'b0;
  logic          rst      = 1'b1;
  logic          fft_valid = 1'b0;
  logic          fft_sop   = 1'b0;
  logic          fft_eop   = 1'b0;
  logic [DW-1:0] fft_real  = '0;
  logic [DW-1:0] fft_imag  = '0;
  logic          fft_ready;
  logic          rd_ready  = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_real;
  logic [DW-1:0] rd_imag;
  logic          rd_last;
  logic          err_sop;
  logic          err_len;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;
  int rd_mode = 0;
  bit mon_en = 1'b0;

  // Reference model state: samples of the frame being received, committed samples
  // awaiting replay, number of stored frames, and expected error pulses for next cycle.
  beat_t        cur[$];
  bit           in_frame;
  beat_t        exp_q[$];
  int           stored;
  logic [15:0]  m_cnt;
  int           rd_idx;
  bit           p_err_sop;
  bit           p_err_len;
  bit           hold_prev;
  logic [2*DW:0] hold_val;
  int           n_err_sop = 0;
  int           n_err_len = 0;

  fft_frame_sink #(.DW(DW), .FFT_LEN(FFT_LEN), .AW(AW)) dut (
    .clk_100m (clk_100m),
    .rst      (rst),
    .fft_valid(fft_valid),
    .fft_sop  (fft_sop),
    .fft_eop  (fft_eop),
    .fft_real (fft_real),
    .fft_imag (fft_imag),
    .fft_ready(fft_ready),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_real  (rd_real),
    .rd_imag  (rd_imag),
    .rd_last  (rd_last),
    .err_sop  (err_sop),
    .err_len  (err_len),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    exp_q.delete();
    in_frame  = 1'b0;
    stored    = 0;
    m_cnt     = '0;
    rd_idx    = 0;
    p_err_sop = 1'b0;
    p_err_len = 1'b0;
    hold_prev = 1'b0;
  endtask

  task automatic model_beat(input bit s, input bit e, input beat_t d);
    if (s) begin
      if (in_frame) p_err_sop = 1'b1;
      cur.delete();
      cur.push_back(d);
      in_frame = 1'b1;
    end else if (in_frame) begin
      cur.push_back(d);
    end
    if (in_frame && (e || cur.size() == FFT_LEN)) begin
      if (e && cur.size() == FFT_LEN) begin
        foreach (cur[i]) exp_q.push_back(cur[i]);
        stored++;
        m_cnt++;
      end else begin
        p_err_len = 1'b1;
      end
      in_frame = 1'b0;
    end
  endtask

  // Monitor: at each falling edge, check what the last rising edge produced, then
  // feed the handshakes that the next rising edge will complete into the model.
  always @(negedge clk_100m) begin
    if (mon_en) begin
      if (rst) begin
        model_reset();
      end else begin
        if (err_sop) n_err_sop++;
        if (err_len) n_err_len++;
        check("fft_ready", fft_ready, stored < 2);
        check("frame_cnt", frame_cnt, m_cnt);
        check("err_sop", err_sop, p_err_sop);
        check("err_len", err_len, p_err_len);
        if (hold_prev) begin
          check("hold_valid", rd_valid, 1);
          check("hold_data", {rd_real, rd_imag, rd_last}, hold_val);
        end
        if (rd_valid) check("rd_spurious", exp_q.size() != 0, 1);
        p_err_sop = 1'b0;
        p_err_len = 1'b0;
        if (rd_valid && rd_ready && exp_q.size() != 0) begin
          check("rd_data", {rd_real, rd_imag}, exp_q[0]);
          check("rd_last", rd_last, rd_idx == FFT_LEN - 1);
          void'(exp_q.pop_front());
          rd_idx++;
          if (rd_idx == FFT_LEN) begin
            rd_idx = 0;
            stored--;
          end
        end
        hold_prev = rd_valid & ~rd_ready;
        hold_val  = {rd_real, rd_imag, rd_last};
        if (fft_valid && fft_ready) model_beat(fft_sop, fft_eop, {fft_real, fft_imag});
      end
    end
  end

  // rd_ready pattern: 0 = held low, 1 = held high, 2 = toggling, 3 = random.
  always @(posedge clk_100m) begin
    #1;
    case (rd_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      2:       rd_ready = ~rd_ready;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    repeat (60000) @(posedge clk_100m);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100m);
      #1;
    end
  endtask

  task automatic drive(input bit s, input bit e, input logic [DW-1:0] re,
                       input logic [DW-1:0] im, input bit gaps);
    int w = 0;
    fft_valid = 1'b1;
    fft_sop   = s;
    fft_eop   = e;
    fft_real  = re;
    fft_imag  = im;
    @(negedge clk_100m);
    while (!fft_ready && w < TIMEOUT) begin
      @(negedge clk_100m);
      w++;
    end
    if (!fft_ready) check("beat_accept_timeout", fft_ready, 1);
    @(posedge clk_100m);
    #1;
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
    if (gaps && $urandom_range(0, 5) == 0) tick(1);
  endtask

  task automatic send_frame(input int len, input int eop_at, input bit idx_pat, input bit gaps);
    logic [DW-1:0] re, im;
    for (int i = 0; i < len; i++) begin
      re = idx_pat ? DW'(i) : DW'($urandom());
      im = idx_pat ? ~(DW'(i)) : DW'($urandom());
      drive(i == 0, i == eop_at, re, im, gaps);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rd_valid) && n < 20000) begin
      tick(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_idle"}, rd_valid, 0);
  endtask

  initial begin
    int n;
    int el0, es0;
    logic [15:0] c0;

    // Reset values
    rst    = 1'b1;
    mon_en = 1'b1;
    tick(3);
    check("rst_fft_ready", fft_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_real", rd_real, 0);
    check("rst_rd_imag", rd_imag, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_err_sop", err_sop, 0);
    check("rst_err_len", err_len, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;

    // 1: single good frame, real = index, imag = ~index
    rd_mode = 1;
    tick(2);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b1, 1'b0);
    // The eop beat occupied cycle t; we resume in cycle t+1, so rd_valid is due after one more edge.
    n = 0;
    while (!rd_valid && n < 20) begin
      tick(1);
      n++;
    end
    check("t1_latency", n, 1);
    wait_drain("t1_drain");
    check("t1_frame_cnt", frame_cnt, 1);

    // 2: three frames with the reader stalled
    rd_mode = 0;
    tick(2);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    check("t2_ready_after_f1", fft_ready, 1);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    check("t2_ready_drop", fft_ready, 0);
    fft_valid = 1'b1;
    fft_sop   = 1'b1;
    fft_real  = DW'($urandom());
    tick(10);
    check("t2_frame3_blocked", fft_ready, 0);
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    rd_mode = 1;
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    wait_drain("t2_drain");
    check("t2_frame_cnt", frame_cnt, 4);

    // 3: early eop at index 100
    c0  = m_cnt;
    el0 = n_err_len;
    send_frame(101, 100, 1'b0, 1'b0);
    tick(10);
    check("t3_err_len_pulses", n_err_len - el0, 1);
    check("t3_frame_cnt", frame_cnt, c0);
    check("t3_no_replay", rd_valid, 0);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    wait_drain("t3_drain");

    // 4: sop at index 50 restarts the frame
    es0 = n_err_sop;
    send_frame(50, -1, 1'b0, 1'b0);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    tick(2);
    check("t4_err_sop_pulses", n_err_sop - es0, 1);
    wait_drain("t4_drain");

    // 5: toggling rd_ready during replay
    rd_mode = 2;
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b1);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b1);
    wait_drain("t5_drain");

    // 6: reset mid-frame while the other bank holds a frame
    rd_mode = 0;
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    rd_mode = 1;
    n = 0;
    while (!fft_ready && n < 2000) begin
      tick(1);
      n++;
    end
    rd_mode = 0;
    check("t6_bank_released", fft_ready, 1);
    send_frame(128, -1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1);
    check("t6_fft_ready", fft_ready, 1);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_rd_data", {rd_real, rd_imag}, 0);
    check("t6_rd_last", rd_last, 0);
    check("t6_errs", {err_sop, err_len}, 0);
    check("t6_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    rd_mode = 1;
    tick(20);
    check("t6_no_replay", rd_valid, 0);
    send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b0);
    wait_drain("t6_drain");
    check("t6_frame_cnt_after", frame_cnt, 1);

    // 7: randomized mix of good and malformed frames with random back-pressure
    rd_mode = 3;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 9))
        0: send_frame($urandom_range(2, FFT_LEN - 1), 0, 1'b0, 1'b1);
        1: send_frame(FFT_LEN, -1, 1'b0, 1'b1);
        2: begin
          send_frame($urandom_range(1, FFT_LEN - 2), -1, 1'b0, 1'b1);
          send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b1);
        end
        3: begin
          drive(1'b0, 1'b0, DW'($urandom()), DW'($urandom()), 1'b0);
          send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b1);
        end
        default: send_frame(FFT_LEN, FFT_LEN - 1, 1'b0, 1'b1);
      endcase
    end
    rd_mode = 1;
    wait_drain("t7_drain");
    check("t7_frame_cnt", frame_cnt, m_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
